// File: rtl/apb_arb_ctrl_0_if.sv
// rtl/apb_arb_ctrl_0_if.sv - APB bus bundle between the arbiter controller and its slaves
interface apb_arb_ctrl_0_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int SLAVE_NUM  = 5
);
   logic [SLAVE_NUM-1:0]            psel;
   logic                            penable;
   logic                            pwrite;
   logic [ADDR_WIDTH-1:0]           paddr;
   logic [DATA_WIDTH-1:0]           pwdata;
   logic [SLAVE_NUM*DATA_WIDTH-1:0] prdata;
   logic [SLAVE_NUM-1:0]            pready;
   logic [SLAVE_NUM-1:0]            pslverr;

   modport master (
      output psel, penable, pwrite, paddr, pwdata,
      input  prdata, pready, pslverr
   );

   modport slave (
      input  psel, penable, pwrite, paddr, pwdata,
      output prdata, pready, pslverr
   );
endinterface

// File: rtl/apb_arb_ctrl_0.sv
// rtl/apb_arb_ctrl_0.sv - round-robin multi-requester APB master with decode error and timeout
module apb_arb_ctrl_0 #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MASTER_NUM     = 2,
   parameter int MASTER_NUM_LOG = 1,
   parameter int SLAVE_NUM      = 5,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             presetn,
   input  logic [MASTER_NUM-1:0]            req,
   input  logic [MASTER_NUM*ADDR_WIDTH-1:0] req_addr,
   input  logic [MASTER_NUM-1:0]            req_write,
   input  logic [MASTER_NUM*DATA_WIDTH-1:0] req_wdata,
   output logic [MASTER_NUM-1:0]            rsp_done,
   output logic                             rsp_err,
   output logic [DATA_WIDTH-1:0]            rsp_rdata,
   output logic [MASTER_NUM_LOG-1:0]        dec_master_id,
   output logic [ADDR_WIDTH-1:0]            dec_addr,
   input  logic [SLAVE_NUM-1:0]             dec_ss,
   apb_arb_ctrl_0_if.master                 apb
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETUP  = 2'd1;
   localparam logic [1:0] ACCESS = 2'd2;
   localparam logic [1:0] DECERR = 2'd3;
   localparam int         TW     = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]                state;
   logic [MASTER_NUM_LOG-1:0] rr_ptr;
   logic [MASTER_NUM_LOG-1:0] gnt_idx;
   logic [SLAVE_NUM-1:0]      psel_q;
   logic                      penable_q;
   logic                      pwrite_q;
   logic [ADDR_WIDTH-1:0]     paddr_q;
   logic [DATA_WIDTH-1:0]     pwdata_q;
   logic [TW-1:0]             tmo_cnt;

   logic                      win_valid;
   logic [MASTER_NUM_LOG-1:0] win_idx;
   logic [ADDR_WIDTH-1:0]     win_addr;
   logic                      win_write;
   logic [DATA_WIDTH-1:0]     win_wdata;
   logic                      sel_ready;
   logic                      sel_err;
   logic [DATA_WIDTH-1:0]     sel_rdata;
   logic                      tmo_hit;
   logic                      done;

   // round-robin pick: smallest distance from the slot after the last grant wins
   always_comb begin
      int best;
      int d;
      best      = MASTER_NUM;
      d         = 0;
      win_valid = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         d = (i + MASTER_NUM - 1 - int'(rr_ptr)) % MASTER_NUM;
         if (req[i] && d < best) begin
            best      = d;
            win_valid = 1'b1;
            win_idx   = MASTER_NUM_LOG'(i);
         end
      end
   end

   // fetch the winner's request fields
   always_comb begin
      win_addr  = '0;
      win_write = 1'b0;
      win_wdata = '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         if (MASTER_NUM_LOG'(i) == win_idx) begin
            win_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            win_write = req_write[i];
            win_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // response signals of the selected slave; psel_q is one-hot or zero so OR-merging is safe
   always_comb begin
      sel_ready = 1'b0;
      sel_err   = 1'b0;
      sel_rdata = '0;
      for (int s = 0; s < SLAVE_NUM; s++) begin
         if (psel_q[s]) begin
            sel_ready = apb.pready[s];
            sel_err   = apb.pslverr[s];
            sel_rdata = apb.prdata[s*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // completion decode: slave ready, timeout in the last allowed ACCESS cycle, or decode error
   always_comb begin
      tmo_hit   = (state == ACCESS) && !sel_ready && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
      done      = ((state == ACCESS) && (sel_ready || tmo_hit)) || (state == DECERR);
      rsp_err   = done && ((state == DECERR) || tmo_hit || sel_err);
      rsp_rdata = ((state == ACCESS) && sel_ready && !pwrite_q) ? sel_rdata : '0;
      for (int i = 0; i < MASTER_NUM; i++) begin
         rsp_done[i] = done && (MASTER_NUM_LOG'(i) == gnt_idx);
      end
   end

   // decoder sees the live winner while arbitrating, the latched grant otherwise
   always_comb begin
      dec_master_id = (state == IDLE) ? win_idx  : gnt_idx;
      dec_addr      = (state == IDLE) ? win_addr : paddr_q;
      apb.psel      = psel_q;
      apb.penable   = penable_q;
      apb.pwrite    = pwrite_q;
      apb.paddr     = paddr_q;
      apb.pwdata    = pwdata_q;
   end

   // transfer sequencing; async reset drops the bus immediately
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state     <= IDLE;
         rr_ptr    <= MASTER_NUM_LOG'(MASTER_NUM - 1);
         gnt_idx   <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         tmo_cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  gnt_idx  <= win_idx;
                  rr_ptr   <= win_idx;
                  paddr_q  <= win_addr;
                  pwrite_q <= win_write;
                  pwdata_q <= win_wdata;
                  tmo_cnt  <= '0;
                  if ($onehot(dec_ss)) begin
                     psel_q <= dec_ss;
                     state  <= SETUP;
                  end else begin
                     psel_q <= '0;
                     state  <= DECERR;
                  end
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state     <= ACCESS;
            end
            ACCESS: begin
               if (done) begin
                  psel_q    <= '0;
                  penable_q <= 1'b0;
                  state     <= IDLE;
               end else begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_apb_arb_ctrl_0.sv
// tb/tb_apb_arb_ctrl_0.sv - directed self-checking bench for apb_arb_ctrl_0
module tb_apb_arb_ctrl_0;
   logic        pclk = 1'b0;
   logic        presetn;
   logic [1:0]  req;
   logic [63:0] req_addr;
   logic [1:0]  req_write;
   logic [63:0] req_wdata;
   logic [1:0]  rsp_done;
   logic        rsp_err;
   logic [31:0] rsp_rdata;
   logic [0:0]  dec_master_id;
   logic [31:0] dec_addr;
   logic [4:0]  dec_ss;

   int n_cmp = 0;
   int n_err = 0;

   apb_arb_ctrl_0_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .SLAVE_NUM(5)) apb_if ();

   apb_arb_ctrl_0 dut (
      .pclk          (pclk),
      .presetn       (presetn),
      .req           (req),
      .req_addr      (req_addr),
      .req_write     (req_write),
      .req_wdata     (req_wdata),
      .rsp_done      (rsp_done),
      .rsp_err       (rsp_err),
      .rsp_rdata     (rsp_rdata),
      .dec_master_id (dec_master_id),
      .dec_addr      (dec_addr),
      .dec_ss        (dec_ss),
      .apb           (apb_if)
   );

   always #5 pclk = ~pclk;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   initial begin
      presetn          = 1'b0;
      req              = 2'b00;
      req_addr         = '0;
      req_write        = 2'b00;
      req_wdata        = '0;
      dec_ss           = 5'b00000;
      apb_if.pready    = 5'b00000;
      apb_if.pslverr   = 5'b00000;
      for (int s = 0; s < 5; s++) apb_if.prdata[s*32 +: 32] = 32'hD000_0000 | s;

      // reset state
      step(); step();
      #1;
      chk("rst_psel", 64'(apb_if.psel), 64'h0);
      chk("rst_penable", 64'(apb_if.penable), 64'h0);
      chk("rst_pwrite", 64'(apb_if.pwrite), 64'h0);
      chk("rst_paddr", 64'(apb_if.paddr), 64'h0);
      chk("rst_pwdata", 64'(apb_if.pwdata), 64'h0);
      chk("rst_done", 64'(rsp_done), 64'h0);
      step();
      presetn = 1'b1;

      // both request: requester 0 reads first, slave 3, ready on first ACCESS
      step();
      req            = 2'b11;
      req_addr       = {32'h0003_0020, 32'h0002_0010};
      req_write      = 2'b10;
      req_wdata      = {32'h1234_5678, 32'hFFFF_0000};
      dec_ss         = 5'b01000;
      apb_if.pready  = 5'b01000;
      #1;
      chk("a_idle_id", 64'(dec_master_id), 64'h0);
      chk("a_idle_addr", 64'(dec_addr), 64'h0002_0010);
      chk("a_idle_psel", 64'(apb_if.psel), 64'h0);
      chk("a_idle_done", 64'(rsp_done), 64'h0);
      step(); #1;
      chk("a_setup_psel", 64'(apb_if.psel), 64'h08);
      chk("a_setup_pen", 64'(apb_if.penable), 64'h0);
      chk("a_setup_paddr", 64'(apb_if.paddr), 64'h0002_0010);
      chk("a_setup_pwrite", 64'(apb_if.pwrite), 64'h0);
      chk("a_setup_id", 64'(dec_master_id), 64'h0);
      chk("a_setup_done", 64'(rsp_done), 64'h0);
      step(); #1;
      chk("a_acc_psel", 64'(apb_if.psel), 64'h08);
      chk("a_acc_pen", 64'(apb_if.penable), 64'h1);
      chk("a_acc_done", 64'(rsp_done), 64'h1);
      chk("a_acc_rdata", 64'(rsp_rdata), 64'hD000_0003);
      chk("a_acc_err", 64'(rsp_err), 64'h0);
      req = 2'b10;

      // requester 1 writes slave 1, three wait states, slave error
      step();
      dec_ss         = 5'b00010;
      apb_if.pready  = 5'b00000;
      apb_if.pslverr = 5'b00010;
      #1;
      chk("b_idle_psel", 64'(apb_if.psel), 64'h0);
      chk("b_idle_pen", 64'(apb_if.penable), 64'h0);
      chk("b_idle_done", 64'(rsp_done), 64'h0);
      chk("b_idle_id", 64'(dec_master_id), 64'h1);
      chk("b_idle_addr", 64'(dec_addr), 64'h0003_0020);
      step(); #1;
      chk("b_setup_psel", 64'(apb_if.psel), 64'h02);
      chk("b_setup_pwrite", 64'(apb_if.pwrite), 64'h1);
      chk("b_setup_pwdata", 64'(apb_if.pwdata), 64'h1234_5678);
      chk("b_setup_pen", 64'(apb_if.penable), 64'h0);
      for (int c = 0; c < 4; c++) begin
         step();
         if (c == 3) apb_if.pready = 5'b00010;
         #1;
         chk($sformatf("b_acc%0d_psel", c), 64'(apb_if.psel), 64'h02);
         chk($sformatf("b_acc%0d_pen", c), 64'(apb_if.penable), 64'h1);
         chk($sformatf("b_acc%0d_paddr", c), 64'(apb_if.paddr), 64'h0003_0020);
         chk($sformatf("b_acc%0d_pwdata", c), 64'(apb_if.pwdata), 64'h1234_5678);
         chk($sformatf("b_acc%0d_pwrite", c), 64'(apb_if.pwrite), 64'h1);
         chk($sformatf("b_acc%0d_done", c), 64'(rsp_done), (c == 3) ? 64'h2 : 64'h0);
      end
      chk("b_err", 64'(rsp_err), 64'h1);
      chk("b_rdata", 64'(rsp_rdata), 64'h0);
      req = 2'b00;
      step(); #1;
      chk("b_end_psel", 64'(apb_if.psel), 64'h0);
      chk("b_end_done", 64'(rsp_done), 64'h0);

      // decode errors: no slave selected, then two slaves selected
      for (int t = 0; t < 2; t++) begin
         apb_if.pslverr = 5'b00000;
         apb_if.pready  = 5'b11111;
         req      = 2'b01;
         req_addr = {32'h0003_0020, 32'h0005_0000};
         dec_ss   = (t == 0) ? 5'b00000 : 5'b00011;
         #1;
         chk($sformatf("d%0d_idle_id", t), 64'(dec_master_id), 64'h0);
         chk($sformatf("d%0d_idle_done", t), 64'(rsp_done), 64'h0);
         step(); #1;
         chk($sformatf("d%0d_psel", t), 64'(apb_if.psel), 64'h0);
         chk($sformatf("d%0d_pen", t), 64'(apb_if.penable), 64'h0);
         chk($sformatf("d%0d_done", t), 64'(rsp_done), 64'h1);
         chk($sformatf("d%0d_err", t), 64'(rsp_err), 64'h1);
         chk($sformatf("d%0d_rdata", t), 64'(rsp_rdata), 64'h0);
         req = 2'b00;
         step(); #1;
         chk($sformatf("d%0d_after", t), 64'(rsp_done), 64'h0);
         chk($sformatf("d%0d_after_psel", t), 64'(apb_if.psel), 64'h0);
      end

      // timeout: requester 1 reads slave 2 which never answers
      apb_if.pready = 5'b00000;
      req      = 2'b10;
      req_write = 2'b00;
      dec_ss   = 5'b00100;
      #1;
      chk("t_idle_id", 64'(dec_master_id), 64'h1);
      step(); #1;
      chk("t_setup_psel", 64'(apb_if.psel), 64'h04);
      for (int c = 1; c <= 16; c++) begin
         step(); #1;
         chk($sformatf("t_acc%0d_pen", c), 64'(apb_if.penable), 64'h1);
         chk($sformatf("t_acc%0d_done", c), 64'(rsp_done), (c == 16) ? 64'h2 : 64'h0);
      end
      chk("t_err", 64'(rsp_err), 64'h1);
      chk("t_rdata", 64'(rsp_rdata), 64'h0);
      req = 2'b00;
      step(); #1;
      chk("t_end_psel", 64'(apb_if.psel), 64'h0);
      chk("t_end_pen", 64'(apb_if.penable), 64'h0);
      chk("t_end_done", 64'(rsp_done), 64'h0);

      // both request after granting 1: requester 0 is next
      req    = 2'b11;
      dec_ss = 5'b00001;
      #1;
      chk("rr_id", 64'(dec_master_id), 64'h0);

      // reset in the middle of ACCESS
      step(); step(); #1;
      chk("r_acc_pen", 64'(apb_if.penable), 64'h1);
      chk("r_acc_psel", 64'(apb_if.psel), 64'h01);
      #2;
      presetn = 1'b0;
      #1;
      chk("r_psel", 64'(apb_if.psel), 64'h0);
      chk("r_pen", 64'(apb_if.penable), 64'h0);
      chk("r_done", 64'(rsp_done), 64'h0);
      apb_if.pready = 5'b00001;
      #1;
      chk("r_done_rdy", 64'(rsp_done), 64'h0);
      step(); step();
      presetn = 1'b1;
      #1;
      chk("r_after_id", 64'(dec_master_id), 64'h0);
      chk("r_after_psel", 64'(apb_if.psel), 64'h0);
      step(); #1;
      chk("r_after_setup", 64'(apb_if.psel), 64'h01);
      chk("r_after_done", 64'(rsp_done), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/apb_arb_ctrl_0.md
APB_ARB_CTRL_0 -- requirements
Module: apb_arb_ctrl_0

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter MASTER_NUM, default 2, number of requesters.
REQ-004 SHALL have parameter MASTER_NUM_LOG, default 1, width of the requester index.
REQ-005 SHALL have parameter SLAVE_NUM, default 5, number of APB slaves.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 16, maximum ACCESS cycles before abort.
REQ-007 SHALL have the following ports (name, direction, width, meaning):
- pclk  in  1  clock.
- presetn  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  MASTER_NUM  per-requester transfer request, level, held until its rsp_done.
- req_addr  in  MASTER_NUM*ADDR_WIDTH  per-requester address, slice i for requester i.
- req_write  in  MASTER_NUM  per-requester write (1) / read (0).
- req_wdata  in  MASTER_NUM*DATA_WIDTH  per-requester write data.
- rsp_done  out  MASTER_NUM  one-hot completion pulse to the owning requester.
- rsp_err  out  1  error qualifier, valid only while any rsp_done is high.
- rsp_rdata  out  DATA_WIDTH  read data, valid only while any rsp_done is high.
- dec_master_id  out  MASTER_NUM_LOG  requester index driven to the address decoder.
- dec_addr  out  ADDR_WIDTH  address driven to the address decoder.
- dec_ss  in  SLAVE_NUM  decoder slave-select result (combinational from dec_*).
- psel  out  SLAVE_NUM  APB select, one-hot or zero.
- penable, pwrite  out  1  APB enable; APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- prdata  in  SLAVE_NUM*DATA_WIDTH  per-slave read data.
- pready, pslverr  in  SLAVE_NUM  per-slave ready; per-slave error.

Function
REQ-008 SHALL implement FSM states IDLE, SETUP, ACCESS, DECERR.
REQ-009 SHALL, in IDLE, select a winner among asserted req bits round-robin, starting the search at (last granted index + 1) mod MASTER_NUM.
REQ-010 SHALL, in IDLE, drive dec_master_id/dec_addr combinationally from the current winner; in all other states, drive them from the latched grant.
REQ-011 SHALL, in IDLE with a winner, latch the winner's index, address, write and wdata, and update the round-robin pointer to that index.
REQ-012 SHALL, in the same transition, move to SETUP with psel = dec_ss if dec_ss has exactly one bit set; otherwise SHALL move to DECERR with psel = 0.
REQ-013 SHALL, in SETUP, drive penable=0 and psel/paddr/pwrite/pwdata from the latched values, then go to ACCESS unconditionally.
REQ-014 SHALL, in ACCESS, hold penable=1 with all APB outputs stable until the selected slave's pready is 1.
REQ-015 SHALL, in the ACCESS cycle where the selected pready=1, assert rsp_done[granted]=1 combinationally, with rsp_rdata = selected prdata (0 on write) and rsp_err = selected pslverr; the next state SHALL be IDLE with psel=0 and penable=0.
REQ-016 SHALL count ACCESS cycles; if the count reaches TIMEOUT_CYCLES without pready, SHALL assert rsp_done[granted]=1 with rsp_err=1 and rsp_rdata=0 in that cycle, then go to IDLE.
REQ-017 SHALL, in DECERR (one cycle), assert rsp_done[granted]=1 with rsp_err=1 and rsp_rdata=0, then go to IDLE; no APB access occurs.
REQ-018 SHALL give a minimum latency of 3 cycles from req sampled in IDLE to rsp_done (IDLE, SETUP, ACCESS with pready=1), and 2 cycles for a decode error.
REQ-019 SHALL ignore req changes from non-granted requesters until the next IDLE; a drop of the granted requester's req mid-transfer SHALL NOT abort the transfer.
REQ-020 SHALL hold rsp_done at 0 in every cycle other than those stated in REQ-015 to REQ-017, and SHALL never assert more than one rsp_done bit.

Reset
REQ-021 SHALL, while presetn=0 (asynchronously, including mid-transfer), force state IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0, rsp_done=0, the timeout count to 0, and the round-robin pointer to MASTER_NUM-1 so that requester 0 wins first.

Verification
REQ-022 SHALL verify: after reset, req=2'b11 -> requester 0 is granted first, then requester 1 after rsp_done[0] and the drop of req[0].
REQ-023 SHALL verify: requester 0 reads 0x0002_0010 with dec_ss=5'b01000 and pready high on the first ACCESS cycle -> psel[3] is high for 2 cycles, penable only in the second, rsp_done[0] in cycle 3, rsp_rdata equals prdata slice 3.
REQ-024 SHALL verify: a write with pready held low for 3 ACCESS cycles -> APB outputs are stable for 4 ACCESS cycles, and rsp_done fires with rsp_err=pslverr.
REQ-025 SHALL verify: dec_ss=0 (address 0x0005_0000), and separately dec_ss=5'b00011 -> DECERR, psel stays 0, rsp_done with rsp_err=1 two cycles after the request.
REQ-026 SHALL verify: pready stuck low -> rsp_done with rsp_err=1 after TIMEOUT_CYCLES=16 ACCESS cycles, then IDLE.
REQ-027 SHALL verify: presetn asserted during ACCESS -> psel and penable drop immediately without waiting for pclk, and no rsp_done is generated.
